// File: rtl/jleightcap_pin_serdes.sv
// Pin-level SERDES: assembles narrow instruction beats into core words and
// slices core results onto result pins. Optional macro: JLEIGHTCAP_SERDES_PARITY_EN.
module jleightcap_pin_serdes #(
    parameter int INSTR_W   = 12,
    parameter int PIN_IN_W  = 6,
    parameter int OUT_W     = 10,
    parameter int PIN_OUT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIN_IN_W-1:0]  pin_in,
    input  logic                 pin_sof,
    output logic [INSTR_W-1:0]   core_instr,
    output logic                 core_instr_valid,
    input  logic                 core_ready,
    input  logic [OUT_W-1:0]     core_res,
    input  logic                 core_res_valid,
    output logic                 core_res_ready,
    input  logic                 core_cjump,
    output logic [PIN_OUT_W-1:0] pin_out,
    output logic                 pin_out_first,
    output logic                 pin_cjump,
    output logic                 overrun
);
    localparam int IN_BEATS  = (INSTR_W + PIN_IN_W - 1) / PIN_IN_W;
    localparam int OUT_BEATS = (OUT_W + PIN_OUT_W - 1) / PIN_OUT_W;
`ifdef JLEIGHTCAP_SERDES_PARITY_EN
    localparam int FRAME_BEATS = OUT_BEATS + 1;
`else
    localparam int FRAME_BEATS = OUT_BEATS;
`endif
    localparam int IBUF_W = IN_BEATS * PIN_IN_W;
    localparam int SH_W   = FRAME_BEATS * PIN_OUT_W;
    localparam int CNT_W  = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int SCNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} des_state_t;

    des_state_t         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n, cap_idx;
    logic               cap, set_ovr;
    logic [IBUF_W-1:0]  instr_buf;

    // A new frame always starts at beat 0; with a single-beat frame it is complete at once.
    function automatic des_state_t sof_next();
        return (IN_BEATS == 1) ? HOLD : COLLECT;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (set_ovr) overrun <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap     = 1'b0;
        cap_idx = '0;
        set_ovr = 1'b0;
        unique case (state)
            IDLE: begin
                if (pin_sof) begin
                    cap     = 1'b1;
                    cnt_n   = (IN_BEATS > 1) ? CNT_W'(1) : '0;
                    state_n = sof_next();
                end
            end
            COLLECT: begin
                cap = 1'b1;
                if (pin_sof) begin
                    cnt_n   = CNT_W'(1);
                    state_n = sof_next();
                end else begin
                    cap_idx = cnt;
                    if (cnt == CNT_W'(IN_BEATS - 1)) begin
                        cnt_n   = '0;
                        state_n = HOLD;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (core_ready) begin
                    if (pin_sof) begin
                        cap     = 1'b1;
                        cnt_n   = (IN_BEATS > 1) ? CNT_W'(1) : '0;
                        state_n = sof_next();
                    end else begin
                        state_n = IDLE;
                    end
                end else if (pin_sof) begin
                    set_ovr = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_buf <= '0;
        end else if (cap) begin
            instr_buf[int'(cap_idx) * PIN_IN_W +: PIN_IN_W] <= pin_in;
        end
    end

    assign core_instr       = instr_buf[INSTR_W-1:0];
    assign core_instr_valid = (state == HOLD);

    // Serializer: the whole frame (data, zero padding, optional parity beat) is
    // loaded into a shift register; beat 0 goes straight to the pins.
    logic              sbusy;
    logic [SCNT_W-1:0] sbeat;
    logic [SH_W-1:0]   res_sh, load_vec;
    logic              res_xfer;

    always_comb begin
        load_vec            = '0;
        load_vec[OUT_W-1:0] = core_res;
`ifdef JLEIGHTCAP_SERDES_PARITY_EN
        load_vec[OUT_BEATS*PIN_OUT_W] = ^core_res;
`endif
    end

    assign core_res_ready = !sbusy || (sbeat == SCNT_W'(FRAME_BEATS - 1));
    assign res_xfer       = core_res_valid && core_res_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sbusy         <= 1'b0;
            sbeat         <= '0;
            res_sh        <= '0;
            pin_out       <= '0;
            pin_out_first <= 1'b0;
        end else if (res_xfer) begin
            sbusy         <= 1'b1;
            sbeat         <= '0;
            pin_out       <= load_vec[PIN_OUT_W-1:0];
            pin_out_first <= 1'b1;
            res_sh        <= load_vec >> PIN_OUT_W;
        end else if (sbusy) begin
            pin_out_first <= 1'b0;
            if (sbeat == SCNT_W'(FRAME_BEATS - 1)) begin
                sbusy   <= 1'b0;
                sbeat   <= '0;
                pin_out <= '0;
            end else begin
                sbeat   <= sbeat + SCNT_W'(1);
                pin_out <= res_sh[PIN_OUT_W-1:0];
                res_sh  <= res_sh >> PIN_OUT_W;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pin_cjump <= 1'b0;
        else      pin_cjump <= core_cjump;
    end
endmodule

// File: tb/tb_jleightcap_pin_serdes.sv
// Directed bench for jleightcap_pin_serdes at default parameters.
module tb_jleightcap_pin_serdes;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  pin_in = '0;
    logic        pin_sof = 1'b0;
    logic [11:0] core_instr;
    logic        core_instr_valid;
    logic        core_ready = 1'b0;
    logic [9:0]  core_res = '0;
    logic        core_res_valid = 1'b0;
    logic        core_res_ready;
    logic        core_cjump = 1'b0;
    logic [4:0]  pin_out;
    logic        pin_out_first;
    logic        pin_cjump;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    jleightcap_pin_serdes dut (
        .clk(clk), .rst(rst), .pin_in(pin_in), .pin_sof(pin_sof),
        .core_instr(core_instr), .core_instr_valid(core_instr_valid),
        .core_ready(core_ready), .core_res(core_res),
        .core_res_valid(core_res_valid), .core_res_ready(core_res_ready),
        .core_cjump(core_cjump), .pin_out(pin_out),
        .pin_out_first(pin_out_first), .pin_cjump(pin_cjump),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [4:0] b, input logic f);
        check({tag, "_pin_out"}, 32'(pin_out), 32'(b));
        check({tag, "_first"}, 32'(pin_out_first), 32'(f));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_instr", 32'(core_instr), 0);
        check("rst_valid", 32'(core_instr_valid), 0);
        check("rst_pin_out", 32'(pin_out), 0);
        check("rst_first", 32'(pin_out_first), 0);
        check("rst_cjump", 32'(pin_cjump), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_res_ready", 32'(core_res_ready), 1);
        tick();
        rst = 1'b1;
        tick();

        // Basic two-beat frame, accepted immediately
        pin_sof = 1; pin_in = 6'h15; core_ready = 1; tick();
        check("collect_valid", 32'(core_instr_valid), 0);
        pin_sof = 0; pin_in = 6'h2A; tick();
        check("hold_instr", 32'(core_instr), 32'hA95);
        check("hold_valid", 32'(core_instr_valid), 1);
        pin_in = 6'h3F; tick();
        check("valid_one_cycle", 32'(core_instr_valid), 0);
        tick();
        check("idle_ignores_pin", 32'(core_instr_valid), 0);

        // Overrun while holding
        core_ready = 0; pin_sof = 1; pin_in = 6'h15; tick();
        pin_sof = 0; pin_in = 6'h2A; tick();
        check("hold2_valid", 32'(core_instr_valid), 1);
        pin_sof = 1; pin_in = 6'h01; tick();
        check("ovr_set", 32'(overrun), 1);
        check("ovr_instr_kept", 32'(core_instr), 32'hA95);
        check("ovr_still_hold", 32'(core_instr_valid), 1);
        pin_sof = 0; core_ready = 1; tick();
        check("ovr_valid_drop", 32'(core_instr_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);

        // Restart in COLLECT
        core_ready = 0; pin_sof = 1; pin_in = 6'h11; tick();
        pin_sof = 1; pin_in = 6'h07; tick();
        check("restart_not_hold", 32'(core_instr_valid), 0);
        pin_sof = 0; pin_in = 6'h22; tick();
        check("restart_instr", 32'(core_instr), 32'h887);
        check("restart_valid", 32'(core_instr_valid), 1);

        // Accept and new sof in the same cycle
        core_ready = 1; pin_sof = 1; pin_in = 6'h3F; tick();
        check("b2b_valid_low", 32'(core_instr_valid), 0);
        pin_sof = 0; pin_in = 6'h00; tick();
        check("b2b_instr", 32'(core_instr), 32'h03F);
        check("b2b_valid", 32'(core_instr_valid), 1);
        check("b2b_no_new_ovr", 32'(overrun), 1);
        tick();
        check("b2b_done", 32'(core_instr_valid), 0);

        // Conditional jump flag delay
        core_cjump = 1; #1;
        check("cjump_not_yet", 32'(pin_cjump), 0);
        tick();
        check("cjump_hi", 32'(pin_cjump), 1);
        core_cjump = 0; tick();
        check("cjump_lo", 32'(pin_cjump), 0);

        // Single result frame
        core_res = 10'h3A5; core_res_valid = 1; tick();
        core_res_valid = 0;
        check_beat("r1_b0", 5'h05, 1);
        check("r1_ready_mid", 32'(core_res_ready), 0);
        tick();
        check_beat("r1_b1", 5'h1D, 0);
`ifdef JLEIGHTCAP_SERDES_PARITY_EN
        tick();
        check_beat("r1_par", 5'h00, 0);
`endif
        tick();
        check_beat("r1_idle", 5'h00, 0);
        check("r1_ready_idle", 32'(core_res_ready), 1);

        // Back-to-back results
        core_res = 10'h3A5; core_res_valid = 1; tick();
        core_res = 10'h001;
        check_beat("bb_b0", 5'h05, 1);
        tick();
        check_beat("bb_b1", 5'h1D, 0);
`ifdef JLEIGHTCAP_SERDES_PARITY_EN
        tick();
        check_beat("bb_par0", 5'h00, 0);
`endif
        tick();
        core_res_valid = 0;
        check_beat("bb_b2", 5'h01, 1);
        tick();
        check_beat("bb_b3", 5'h00, 0);
`ifdef JLEIGHTCAP_SERDES_PARITY_EN
        tick();
        check_beat("bb_par1", 5'h01, 0);
`endif
        tick();
        check_beat("bb_idle", 5'h00, 0);

        // Reset mid-COLLECT and mid-result-frame
        pin_sof = 1; pin_in = 6'h15; core_ready = 0;
        core_res = 10'h3A5; core_res_valid = 1; core_cjump = 1; tick();
        pin_sof = 0; core_res_valid = 0; pin_in = 6'h2A;
        check_beat("pre_rst_b0", 5'h05, 1);
        check("pre_rst_instr", 32'(core_instr), 32'h015);
        rst = 0; #1;
        check("arst_instr", 32'(core_instr), 0);
        check("arst_valid", 32'(core_instr_valid), 0);
        check_beat("arst_out", 5'h00, 0);
        check("arst_cjump", 32'(pin_cjump), 0);
        check("arst_overrun", 32'(overrun), 0);
        core_cjump = 0;
        tick();
        rst = 1; tick();
        check("post_rst_no_hold", 32'(core_instr_valid), 0);
        check_beat("post_rst_out", 5'h00, 0);

        // Fresh frame after reset
        pin_sof = 1; pin_in = 6'h15; tick();
        pin_sof = 0; pin_in = 6'h2A; tick();
        check("fresh_instr", 32'(core_instr), 32'hA95);
        check("fresh_valid", 32'(core_instr_valid), 1);
        check("fresh_overrun", 32'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
